// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end: machine width, reset vector,
// the ebreak encoding and the fetch-stage state type.
package npc_pkg;

    localparam int          XLEN        = 64;
    localparam logic [63:0] RESET_PC    = 64'h8000_0000;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Fixed encodings so waveforms and older tooling see stable state codes.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    typedef enum logic [2:0] {
        IFU_IDLE = ST_IDLE,
        IFU_REQ  = ST_REQ,
        IFU_WAIT = ST_WAIT,
        IFU_OUT  = ST_OUT,
        IFU_HALT = ST_HALT
    } ifu_state_e;

    function automatic logic is_ebreak(input logic [31:0] word);
        return word == INST_EBREAK;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding instruction-memory request, hands
// each word and its PC to decode, and latches a sticky halt on a consumed ebreak.
module ifu_fetch #(
    parameter int                XLEN     = npc_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = npc_pkg::RESET_PC
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halt
);
    import npc_pkg::*;

    ifu_state_e      state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [31:0]     inst_reg, inst_next;
    logic            drop_reg, drop_next;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        drop_next  = drop_reg;
        case (state_reg)
            IFU_IDLE: state_next = IFU_REQ;
            IFU_REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    // A request accepted in the redirect cycle carries the old pc.
                    if (mem_req_ready) begin
                        state_next = IFU_WAIT;
                        drop_next  = 1'b1;
                    end
                end else if (mem_req_ready) begin
                    state_next = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (mem_rsp_valid) begin
                        state_next = IFU_REQ;
                        drop_next  = 1'b0;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    if (drop_reg) begin
                        drop_next  = 1'b0;
                        state_next = IFU_REQ;
                    end else begin
                        inst_next  = mem_rsp_data;
                        state_next = IFU_OUT;
                    end
                end
            end
            IFU_OUT: begin
                // A redirect wins over decode acceptance, even for ebreak.
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = IFU_REQ;
                end else if (inst_ready) begin
                    if (is_ebreak(inst_reg)) begin
                        state_next = IFU_HALT;
                    end else begin
                        pc_next    = pc_reg + XLEN'(4);
                        state_next = IFU_REQ;
                    end
                end
            end
            IFU_HALT: state_next = IFU_HALT;
            default:  state_next = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IFU_IDLE;
            pc_reg    <= RESET_PC;
            inst_reg  <= 32'h0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            drop_reg  <= drop_next;
        end
    end

    assign mem_req_valid = (state_reg == IFU_REQ);
    assign mem_req_addr  = pc_reg;
    assign inst_valid    = (state_reg == IFU_OUT);
    assign inst          = inst_reg;
    assign inst_pc       = pc_reg;
    assign halt          = (state_reg == IFU_HALT);

    // Memory must not answer in the same cycle it accepts the request.
    rsp_in_req_cycle: assert property (@(posedge clock) disable iff (!reset_n)
        !(mem_req_valid && mem_req_ready && mem_rsp_valid));

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run, checked against
// an architectural model (expected fetch PC, halt flag, address-keyed memory).
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt;

    ifu_fetch dut (
        .clock(clock), .reset_n(reset_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // knobs for the input driver
    int p_ready = 100, p_iready = 100, p_redir = 0, lat_min = 1, lat_max = 1;

    // architectural model
    logic [63:0] model_pc = RST_PC;
    logic        model_halt = 1'b0;
    logic [63:0] ebreak_addr = 64'h1;
    int          dec_count = 0;

    // memory responder state
    logic        pending = 1'b0;
    logic [63:0] paddr = 64'h0;
    int          cnt = 0;

    // values sampled at the last negedge
    logic        s_req_valid, s_req_hs, s_dec_hs, s_inst_valid, s_redir;
    logic [63:0] s_addr, s_inst_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] memword(input logic [63:0] a);
        logic [31:0] w;
        if (a == ebreak_addr) return EBRK;
        w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0013;
        if (w == EBRK) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_req_addr", mem_req_addr, RST_PC);
        chk("rst_inst_pc", inst_pc, RST_PC);
        chk("rst_inst", inst, 0);
    endtask

    task automatic drive();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        if (pending) begin
            if (cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = memword(paddr);
            end else begin
                cnt--;
            end
        end
        mem_req_ready  = ($urandom_range(99, 0) < p_ready);
        inst_ready     = ($urandom_range(99, 0) < p_iready);
        redirect_valid = ($urandom_range(99, 0) < p_redir);
        case ($urandom_range(2, 0))
            0:       redirect_pc = RST_PC + 64'($urandom_range(255, 0));
            1:       redirect_pc = {$urandom, $urandom};
            default: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
        endcase
    endtask

    task automatic cycle();
        @(negedge clock);
        s_req_valid  = mem_req_valid;
        s_req_hs     = mem_req_valid && mem_req_ready;
        s_dec_hs     = inst_valid && inst_ready;
        s_inst_valid = inst_valid;
        s_addr       = mem_req_addr;
        s_inst       = inst;
        s_inst_pc    = inst_pc;
        s_redir      = redirect_valid;
        if (reset_n) begin
            chk("halt", halt, model_halt);
            if (model_halt) begin
                chk("halt_req_valid", mem_req_valid, 0);
                chk("halt_inst_valid", inst_valid, 0);
            end
            if (s_req_hs) chk("req_addr", s_addr, model_pc);
            if (s_dec_hs && !s_redir) begin
                chk("dec_pc", s_inst_pc, model_pc);
                chk("dec_inst", s_inst, memword(model_pc));
                dec_count++;
                $display("decode pc=%h inst=%h", s_inst_pc, s_inst);
            end
            if (!model_halt) begin
                if (s_redir) model_pc = {redirect_pc[63:2], 2'b00};
                else if (s_dec_hs) begin
                    if (memword(model_pc) == EBRK) model_halt = 1'b1;
                    else model_pc = model_pc + 64'd4;
                end
            end
        end
        if (mem_rsp_valid) pending = 1'b0;
        if (s_req_hs) begin
            pending = 1'b1;
            paddr   = s_addr;
            cnt     = $urandom_range(lat_max, lat_min) - 1;
        end
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic assert_reset();
        reset_n    = 1'b0;
        model_pc   = RST_PC;
        model_halt = 1'b0;
        #1;
        chk_reset_vals();
    endtask

    initial begin
        int first_rv, first_hs, first_iv, found, nreq, dec0;
        logic [63:0] reqq[$];

        // reset and first fetches with a zero-wait memory
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals();
        reset_n = 1'b1;
        drive();
        first_rv = -1; first_hs = -1; first_iv = -1;
        for (int k = 0; k < 9; k++) begin
            cycle();
            if (s_req_valid && first_rv < 0) first_rv = k;
            if (s_req_hs) begin
                reqq.push_back(s_addr);
                if (first_hs < 0) first_hs = k;
            end
            if (s_inst_valid && first_iv < 0) first_iv = k;
        end
        chk("first_req_cycle", 64'(first_rv), 1);
        chk("hs_to_inst_valid", 64'(first_iv - first_hs), 2);
        chk("req_count", 64'(reqq.size()), 3);
        if (reqq.size() >= 3) begin
            chk("req0", reqq[0], 64'h8000_0000);
            chk("req1", reqq[1], 64'h8000_0004);
            chk("req2", reqq[2], 64'h8000_0008);
        end

        // decode stalls for 5 cycles
        p_iready = 0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (inst_valid && !inst_ready) found = 1;
        end
        chk("stall_reached", 64'(found), 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_valid", s_inst_valid, 1);
            chk("stall_pc", s_inst_pc, model_pc);
            chk("stall_inst", s_inst, memword(model_pc));
            chk("stall_no_req", s_req_valid, 0);
        end
        p_iready = 100;

        // redirect during WAIT drops the in-flight word
        lat_min = 2; lat_max = 2;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_req_hs) found = 1;
        end
        chk("wait_reached", 64'(found), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_inst_valid) chk("no_dropped_word", s_inst_valid, 0);
            if (s_req_hs) found = 1;
        end
        chk("redir_req_seen", 64'(found), 1);
        chk("redir_req_addr", s_addr, 64'h8000_0100);

        // randomized traffic
        p_ready = 70; p_iready = 60; p_redir = 5; lat_min = 1; lat_max = 4;
        dec0 = dec_count;
        for (int k = 0; k < 3000; k++) cycle();
        chk("random_progress", 64'(dec_count - dec0 > 100), 1);

        // ebreak with a simultaneous redirect, then a real halt
        p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 1; lat_max = 2;
        ebreak_addr    = 64'h8000_0008;
        redirect_valid = 1'b1;
        redirect_pc    = RST_PC;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            cycle();
            if (inst_valid && inst_pc == 64'h8000_0008) found = 1;
        end
        chk("ebreak_out_1", 64'(found), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        cycle();
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_req_hs) found = 1;
        end
        chk("no_halt_redir", halt, 0);
        chk("ebreak_redir_addr", s_addr, 64'h8000_0200);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0008;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            cycle();
            if (inst_valid && inst_pc == 64'h8000_0008 && !redirect_valid) found = 1;
        end
        chk("ebreak_out_2", 64'(found), 1);
        chk("halt_before", halt, 0);
        cycle();
        chk("halt_rise", halt, 1);
        p_ready = 50; p_redir = 50;
        nreq = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (s_req_valid) nreq++;
        end
        chk("halt_no_requests", 64'(nreq), 0);
        chk("halt_hold", halt, 1);

        // pc wrap-around at the top of the address space
        p_ready = 100; p_redir = 0;
        assert_reset();
        cycle();
        reset_n = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_req_hs && s_addr == 64'hFFFF_FFFF_FFFF_FFFC) found = 1;
        end
        chk("wrap_top_req", 64'(found), 1);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_req_hs) found = 1;
        end
        chk("wrap_req_seen", 64'(found), 1);
        chk("wrap_req_addr", s_addr, 0);

        // reset pulse while a response is in flight
        lat_min = 4; lat_max = 4;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_req_hs) found = 1;
        end
        chk("wait2_reached", 64'(found), 1);
        p_ready = 0;
        assert_reset();
        cycle();
        cycle();
        reset_n = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            cycle();
            if (!pending) found = 1;
        end
        chk("stale_delivered", 64'(found), 1);
        p_ready = 100; lat_min = 1; lat_max = 3;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_req_hs) found = 1;
        end
        chk("restart_req_seen", 64'(found), 1);
        chk("restart_addr", s_addr, RST_PC);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (s_dec_hs) found = 1;
        end
        chk("restart_dec_seen", 64'(found), 1);
        chk("restart_inst", s_inst, memword(RST_PC));
        chk("restart_inst_pc", s_inst_pc, RST_PC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
